// File: rtl/if_fetch_stage_if.sv
// Instruction-memory fetch bus between if_fetch_stage (master) and instruction memory (slave).
// Carries one-outstanding request/response traffic: req/addr out, rvalid/rdata back.
interface if_fetch_stage_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  imem_req;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic                  imem_rvalid;
  logic [DATA_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage plus IF/ID register: owns the PC, one fetch in flight, stall/flush handling.
// Optional performance counters are built only when IF_PERF_CNT_EN is defined.
module if_fetch_stage #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  if_fetch_stage_if.master      imem,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic [DATA_WIDTH-1:0] id_instr,
  output logic [DATA_WIDTH-1:0] id_pc,
  output logic                  id_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_bubble_cnt
`endif
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] hold_instr_q, hold_instr_d;
  logic [DATA_WIDTH-1:0] id_instr_q, id_instr_d;
  logic [DATA_WIDTH-1:0] id_pc_q, id_pc_d;
  logic                  id_valid_q, id_valid_d;
  logic                  load_new;
  logic [DATA_WIDTH-1:0] new_instr;

  // The request strobe is suppressed while rst is high so the first pulse lands on the first free cycle.
  assign imem.imem_req  = (state_q == S_REQ) && !rst;
  assign imem.imem_addr = pc_q;
  assign id_instr       = id_instr_q;
  assign id_pc          = id_pc_q;
  assign id_valid       = id_valid_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_instr_d = hold_instr_q;
    id_instr_d   = id_instr_q;
    id_pc_d      = id_pc_q;
    id_valid_d   = id_valid_q;
    load_new     = 1'b0;
    new_instr    = imem.imem_rdata;

    unique case (state_q)
      S_REQ:  state_d = S_WAIT;
      S_WAIT: begin
        if (imem.imem_rvalid) begin
          if (!stall_i) begin
            load_new = 1'b1;
            state_d  = S_REQ;
          end else begin
            hold_instr_d = imem.imem_rdata;
            state_d      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!stall_i) begin
          load_new  = 1'b1;
          new_instr = hold_instr_q;
          state_d   = S_REQ;
        end
      end
      S_DROP: if (imem.imem_rvalid) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase

    if (load_new) begin
      id_instr_d = new_instr;
      id_pc_d    = pc_q;
      id_valid_d = 1'b1;
      pc_d       = pc_q + DATA_WIDTH'(4);
    end else if (!stall_i) begin
      id_instr_d = NOP_INSTR;
      id_valid_d = 1'b0;
    end

    // Flush overrides everything; a still-outstanding response must be swallowed in S_DROP.
    if (flush_i) begin
      pc_d         = redirect_pc_i & ~DATA_WIDTH'(3);
      id_instr_d   = NOP_INSTR;
      id_pc_d      = id_pc_q;
      id_valid_d   = 1'b0;
      hold_instr_d = NOP_INSTR;
      unique case (state_q)
        S_REQ:   state_d = S_DROP;
        S_WAIT:  state_d = imem.imem_rvalid ? S_REQ : S_DROP;
        S_HOLD:  state_d = S_REQ;
        S_DROP:  state_d = imem.imem_rvalid ? S_REQ : S_DROP;
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      id_instr_q <= NOP_INSTR;
      id_pc_q    <= '0;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      id_valid_q <= id_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    hold_instr_q <= hold_instr_d;
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_bubble_q, perf_bubble_d;

  always_comb begin
    perf_fetch_d  = perf_fetch_q;
    perf_bubble_d = perf_bubble_q;
    if (load_new && !flush_i) perf_fetch_d = perf_fetch_q + 32'd1;
    if (!id_valid_q && !stall_i) perf_bubble_d = perf_bubble_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_q  <= '0;
      perf_bubble_q <= '0;
    end else begin
      perf_fetch_q  <= perf_fetch_d;
      perf_bubble_q <= perf_bubble_d;
    end
  end

  assign perf_fetch_cnt  = perf_fetch_q;
  assign perf_bubble_cnt = perf_bubble_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: per-cycle vector table with a scoreboard of expected IF/ID contents,
// followed by a hand-written reset-during-fetch sequence.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          NV  = 21;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;
`endif

  if_fetch_stage_if #(.DATA_WIDTH(32)) imem_bus ();

  if_fetch_stage #(
    .DATA_WIDTH(32),
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (imem_bus),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .redirect_pc_i  (redirect_pc_i),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_valid       (id_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        flush;
    logic [31:0] redirect;
    logic        rvalid;
    logic [31:0] rdata;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
    logic        exp_valid;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } exp_t;

  vec_t vecs [NV];
  exp_t sb [$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(logic st, logic fl, logic [31:0] rd, logic rv, logic [31:0] dat,
                              logic ereq, logic [31:0] eaddr, logic [31:0] ein,
                              logic [31:0] epc, logic ev);
    vec_t v;
    v.stall = st; v.flush = fl; v.redirect = rd; v.rvalid = rv; v.rdata = dat;
    v.exp_req = ereq; v.exp_addr = eaddr; v.exp_instr = ein; v.exp_pc = epc; v.exp_valid = ev;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    // stall  flush redirect      rvalid rdata          req addr          instr         pc            valid
    vecs[0]  = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        NOP,          32'h0,        0);
    vecs[1]  = mk(0, 0, 32'h0,        1, 32'h00A00093, 0, 32'h0,        32'h00A00093, 32'h0,        1);
    vecs[2]  = mk(1, 0, 32'h0,        0, 32'h0,        1, 32'h4,        32'h00A00093, 32'h0,        1);
    vecs[3]  = mk(1, 0, 32'h0,        1, 32'h00200113, 0, 32'h4,        32'h00A00093, 32'h0,        1);
    vecs[4]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 32'h4,        32'h00A00093, 32'h0,        1);
    vecs[5]  = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h4,        32'h00200113, 32'h4,        1);
    vecs[6]  = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h8,        NOP,          32'h4,        0);
    vecs[7]  = mk(0, 1, 32'h103,      0, 32'h0,        0, 32'h8,        NOP,          32'h4,        0);
    vecs[8]  = mk(0, 0, 32'h0,        1, 32'hDEADBEEF, 0, 32'h100,      NOP,          32'h4,        0);
    vecs[9]  = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h100,      NOP,          32'h4,        0);
    vecs[10] = mk(0, 0, 32'h0,        1, 32'h00300193, 0, 32'h100,      32'h00300193, 32'h100,      1);
    vecs[11] = mk(1, 1, 32'hFFFFFFFC, 0, 32'h0,        1, 32'h104,      NOP,          32'h100,      0);
    vecs[12] = mk(0, 0, 32'h0,        1, 32'hBADBAD00, 0, 32'hFFFFFFFC, NOP,          32'h100,      0);
    vecs[13] = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'hFFFFFFFC, NOP,          32'h100,      0);
    vecs[14] = mk(0, 0, 32'h0,        1, 32'h00400213, 0, 32'hFFFFFFFC, 32'h00400213, 32'hFFFFFFFC, 1);
    vecs[15] = mk(0, 0, 32'h0,        1, 32'hFEEDFACE, 1, 32'h0,        NOP,          32'hFFFFFFFC, 0);
    vecs[16] = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        NOP,          32'hFFFFFFFC, 0);
    vecs[17] = mk(0, 0, 32'h0,        1, 32'h00500293, 0, 32'h0,        32'h00500293, 32'h0,        1);
    vecs[18] = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h4,        NOP,          32'h0,        0);
    vecs[19] = mk(0, 1, 32'h200,      1, 32'hDEADBEEF, 0, 32'h4,        NOP,          32'h0,        0);
    vecs[20] = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h200,      NOP,          32'h0,        0);

    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; redirect_pc_i = '0;
    imem_bus.imem_rvalid = 1'b0; imem_bus.imem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req",   {31'b0, imem_bus.imem_req}, 32'h0);
    chk("reset_addr",  imem_bus.imem_addr, 32'h0);
    chk("reset_instr", id_instr, NOP);
    chk("reset_pc",    id_pc, 32'h0);
    chk("reset_valid", {31'b0, id_valid}, 32'h0);
`ifdef IF_PERF_CNT_EN
    chk("reset_perf_fetch",  perf_fetch_cnt, 32'h0);
    chk("reset_perf_bubble", perf_bubble_cnt, 32'h0);
`endif
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      stall_i = vecs[i].stall;
      flush_i = vecs[i].flush;
      redirect_pc_i = vecs[i].redirect;
      imem_bus.imem_rvalid = vecs[i].rvalid;
      imem_bus.imem_rdata  = vecs[i].rdata;
      #1;
      chk($sformatf("v%0d_req", i),  {31'b0, imem_bus.imem_req}, {31'b0, vecs[i].exp_req});
      chk($sformatf("v%0d_addr", i), imem_bus.imem_addr, vecs[i].exp_addr);
      sb.push_back('{idx: i, instr: vecs[i].exp_instr, pc: vecs[i].exp_pc, valid: vecs[i].exp_valid});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("v%0d_instr", e.idx), id_instr, e.instr);
      chk($sformatf("v%0d_pc", e.idx),    id_pc, e.pc);
      chk($sformatf("v%0d_valid", e.idx), {31'b0, id_valid}, {31'b0, e.valid});
    end

    // Reset while a fetch to 0x200 is outstanding; its late response must be ignored.
    stall_i = 1'b0; flush_i = 1'b0; redirect_pc_i = '0;
    imem_bus.imem_rvalid = 1'b0; imem_bus.imem_rdata = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_req",   {31'b0, imem_bus.imem_req}, 32'h0);
    chk("midrst_addr",  imem_bus.imem_addr, 32'h0);
    chk("midrst_instr", id_instr, NOP);
    chk("midrst_pc",    id_pc, 32'h0);
    chk("midrst_valid", {31'b0, id_valid}, 32'h0);
`ifdef IF_PERF_CNT_EN
    chk("midrst_perf_fetch",  perf_fetch_cnt, 32'h0);
    chk("midrst_perf_bubble", perf_bubble_cnt, 32'h0);
`endif
    rst = 1'b0;
    imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'hDEADBEEF;
    #1;
    chk("postrst_req",  {31'b0, imem_bus.imem_req}, 32'h1);
    chk("postrst_addr", imem_bus.imem_addr, 32'h0);
    @(posedge clk);
    #1;
    chk("late_rsp_valid", {31'b0, id_valid}, 32'h0);
    chk("late_rsp_instr", id_instr, NOP);
    imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'h00A00093;
    #1;
    chk("postrst_wait_req", {31'b0, imem_bus.imem_req}, 32'h0);
    @(posedge clk);
    #1;
    chk("postrst_instr", id_instr, 32'h00A00093);
    chk("postrst_pc",    id_pc, 32'h0);
    chk("postrst_valid", {31'b0, id_valid}, 32'h1);
    imem_bus.imem_rvalid = 1'b0;
    #1;
    chk("postrst_next_addr", imem_bus.imem_addr, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
